// File: rtl/cov_event_monitor_if.sv
// Report channel of cov_event_monitor: counts, flags and valid/ready.
// master: drives rpt_valid/cnt1..3/sat/drop, samples rpt_ready.
interface cov_event_monitor_if #(
  parameter int CNT_W = 8
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_cnt1;
  logic [CNT_W-1:0] rpt_cnt2;
  logic [CNT_W-1:0] rpt_cnt3;
  logic             rpt_sat;
  logic             rpt_drop;

  modport master (
    output rpt_valid,
    output rpt_cnt1,
    output rpt_cnt2,
    output rpt_cnt3,
    output rpt_sat,
    output rpt_drop,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_cnt1,
    input  rpt_cnt2,
    input  rpt_cnt3,
    input  rpt_sat,
    input  rpt_drop,
    output rpt_ready
  );
endinterface

// File: rtl/cov_event_monitor.sv
// Windowed activity monitor: in1/in2 high cycles, in3 rising edges.
// Ports: CLK, RSTn (sync low), en, clr, in1..in3, busy; rpt (master).
module cov_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic en,
  input  logic clr,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic busy,
  cov_event_monitor_if.master rpt
);
  localparam int WIN_W = 16;
  localparam logic [WIN_W-1:0] WIN_LAST =
    WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] c1_q, c1_d;
  logic [CNT_W-1:0] c2_q, c2_d;
  logic [CNT_W-1:0] c3_q, c3_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             sat_q, sat_d;
  logic             in3_d_q, in3_d_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] r1_q, r1_d;
  logic [CNT_W-1:0] r2_q, r2_d;
  logic [CNT_W-1:0] r3_q, r3_d;
  logic             rsat_q, rsat_d;
  logic             drop_q, drop_d;

  logic [CNT_W:0]   s1, s2, s3;
  logic             xfer, done, win_sat;

  // MSB flags an increment that was clamped at full scale
  function automatic logic [CNT_W:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             inc
  );
    logic ovf;
    ovf = inc && (c == CNT_MAX);
    return {ovf, ovf ? c : c + CNT_W'(inc)};
  endfunction

  always_comb begin
    s1      = sat_inc(c1_q, in1);
    s2      = sat_inc(c2_q, in2);
    s3      = sat_inc(c3_q, in3 & ~in3_d_q);
    win_sat = sat_q | s1[CNT_W] | s2[CNT_W]
            | s3[CNT_W];
    xfer    = valid_q & rpt.rpt_ready;
    done    = 1'b0;
    state_d = state_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    c3_d    = c3_q;
    win_d   = win_q;
    sat_d   = sat_q;
    in3_d_d = in3;
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    rsat_d  = rsat_q;
    drop_d  = drop_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = COUNT;
          win_d   = '0;
        end
      end
      COUNT: begin
        if (!en) begin
          state_d = IDLE;
          c1_d    = '0;
          c2_d    = '0;
          c3_d    = '0;
          win_d   = '0;
          sat_d   = 1'b0;
        end else if (win_q == WIN_LAST) begin
          done  = 1'b1;
          c1_d  = '0;
          c2_d  = '0;
          c3_d  = '0;
          win_d = '0;
          sat_d = 1'b0;
        end else begin
          c1_d  = s1[CNT_W-1:0];
          c2_d  = s2[CNT_W-1:0];
          c3_d  = s3[CNT_W-1:0];
          win_d = win_q + WIN_W'(1);
          sat_d = win_sat;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) valid_d = 1'b0;

    // a finished window may refill the slot freed by this edge's transfer
    if (done) begin
      if (!valid_q || xfer) begin
        valid_d = 1'b1;
        r1_d    = s1[CNT_W-1:0];
        r2_d    = s2[CNT_W-1:0];
        r3_d    = s3[CNT_W-1:0];
        rsat_d  = win_sat;
      end else begin
        drop_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn || clr) begin
      state_q <= IDLE;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      win_q   <= '0;
      sat_q   <= 1'b0;
      in3_d_q <= 1'b0;
      valid_q <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      rsat_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      win_q   <= win_d;
      sat_q   <= sat_d;
      in3_d_q <= in3_d_d;
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      rsat_q  <= rsat_d;
      drop_q  <= drop_d;
    end
  end

  assign busy          = (state_q == COUNT);
  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_cnt1  = r1_q;
  assign rpt.rpt_cnt2  = r2_q;
  assign rpt.rpt_cnt3  = r3_q;
  assign rpt.rpt_sat   = rsat_q;
  assign rpt.rpt_drop  = drop_q;
endmodule

// File: tb/tb_cov_event_monitor.sv
// Bench for cov_event_monitor: two configurations (8/16 and 3/10)
// driven in parallel and checked against a window-sum model.
module tb_cov_event_monitor;
  logic clk = 1'b0;
  logic rstn, en, clr, in1, in2, in3, ready;
  logic busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  cov_event_monitor_if #(.CNT_W(8)) ifa ();
  cov_event_monitor_if #(.CNT_W(3)) ifb ();

  assign ifa.rpt_ready = ready;
  assign ifb.rpt_ready = ready;

  cov_event_monitor #(.CNT_W(8), .WINDOW(16)) dut_a (
    .CLK(clk), .RSTn(rstn), .en(en), .clr(clr),
    .in1(in1), .in2(in2), .in3(in3),
    .busy(busy_a), .rpt(ifa.master)
  );

  cov_event_monitor #(.CNT_W(3), .WINDOW(10)) dut_b (
    .CLK(clk), .RSTn(rstn), .en(en), .clr(clr),
    .in1(in1), .in2(in2), .in3(in3),
    .busy(busy_b), .rpt(ifb.master)
  );

  logic [31:0] a_v[2], a_c1[2], a_c2[2], a_c3[2];
  logic [31:0] a_s[2], a_d[2], a_b[2];
  assign a_v[0]  = 32'(ifa.rpt_valid);
  assign a_c1[0] = 32'(ifa.rpt_cnt1);
  assign a_c2[0] = 32'(ifa.rpt_cnt2);
  assign a_c3[0] = 32'(ifa.rpt_cnt3);
  assign a_s[0]  = 32'(ifa.rpt_sat);
  assign a_d[0]  = 32'(ifa.rpt_drop);
  assign a_b[0]  = 32'(busy_a);
  assign a_v[1]  = 32'(ifb.rpt_valid);
  assign a_c1[1] = 32'(ifb.rpt_cnt1);
  assign a_c2[1] = 32'(ifb.rpt_cnt2);
  assign a_c3[1] = 32'(ifb.rpt_cnt3);
  assign a_s[1]  = 32'(ifb.rpt_sat);
  assign a_d[1]  = 32'(ifb.rpt_drop);
  assign a_b[1]  = 32'(busy_b);

  // model: unbounded window sums, clamped only when reported
  int W[2] = '{16, 10};
  int M[2] = '{255, 7};
  bit m_act[2], m_p3[2], m_v[2], m_sat[2], m_drop[2];
  int m_n[2], m_s1[2], m_s2[2], m_s3[2];
  int m_f1[2], m_f2[2], m_f3[2];

  function automatic int clamp(input int s, input int mx);
    return (s > mx) ? mx : s;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit xfer, done, fs;
      int f1, f2, f3;
      done = 1'b0;
      fs = 1'b0;
      f1 = 0; f2 = 0; f3 = 0;
      if (!rstn || clr) begin
        m_act[k] = 0; m_n[k] = 0; m_p3[k] = 0;
        m_s1[k] = 0; m_s2[k] = 0; m_s3[k] = 0;
        m_v[k] = 0; m_sat[k] = 0; m_drop[k] = 0;
        m_f1[k] = 0; m_f2[k] = 0; m_f3[k] = 0;
      end else begin
        xfer = m_v[k] && ready;
        if (m_act[k]) begin
          if (!en) begin
            m_act[k] = 0; m_n[k] = 0;
            m_s1[k] = 0; m_s2[k] = 0; m_s3[k] = 0;
          end else begin
            m_s1[k] += int'(in1);
            m_s2[k] += int'(in2);
            m_s3[k] += int'(in3 && !m_p3[k]);
            m_n[k]++;
            if (m_n[k] == W[k]) begin
              done = 1'b1;
              f1 = clamp(m_s1[k], M[k]);
              f2 = clamp(m_s2[k], M[k]);
              f3 = clamp(m_s3[k], M[k]);
              fs = (m_s1[k] > M[k]) || (m_s2[k] > M[k])
                || (m_s3[k] > M[k]);
              m_n[k] = 0;
              m_s1[k] = 0; m_s2[k] = 0; m_s3[k] = 0;
            end
          end
        end else if (en) begin
          m_act[k] = 1; m_n[k] = 0;
        end
        if (xfer) m_v[k] = 0;
        if (done) begin
          if (!m_v[k]) begin
            m_v[k] = 1;
            m_f1[k] = f1; m_f2[k] = f2; m_f3[k] = f3;
            m_sat[k] = fs;
          end else begin
            m_drop[k] = 1;
          end
        end
        m_p3[k] = in3;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid%0d", k), a_v[k], int'(m_v[k]));
        chk($sformatf("busy%0d", k), a_b[k], int'(m_act[k]));
        chk($sformatf("drop%0d", k), a_d[k], int'(m_drop[k]));
        chk($sformatf("cnt1_%0d", k), a_c1[k], m_f1[k]);
        chk($sformatf("cnt2_%0d", k), a_c2[k], m_f2[k]);
        chk($sformatf("cnt3_%0d", k), a_c3[k], m_f3[k]);
        chk($sformatf("sat%0d", k), a_s[k], int'(m_sat[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic zero_in();
    in1 = 0; in2 = 0; in3 = 0;
  endtask

  task automatic do_clr();
    clr = 1; tick(); clr = 0;
  endtask

  initial begin
    rstn = 0; clr = 0; ready = 1;
    en = 1; in1 = 1; in2 = 1; in3 = 1;
    tick(); tick();
    chk("rst_valid", a_v[0], 0);
    chk("rst_cnt1", a_c1[0], 0);
    chk("rst_cnt3", a_c3[0], 0);
    chk("rst_drop", a_d[0], 0);
    chk("rst_busy", a_b[0], 0);
    chk_on = 1;

    // basic window
    rstn = 1; en = 0; zero_in(); tick();
    en = 1; tick();
    for (int i = 0; i < 16; i++) begin
      in1 = 1; in2 = 0; in3 = (i % 2 == 1);
      tick();
    end
    chk("basic_valid", a_v[0], 1);
    chk("basic_cnt1", a_c1[0], 16);
    chk("basic_cnt2", a_c2[0], 0);
    chk("basic_cnt3", a_c3[0], 8);
    chk("basic_sat", a_s[0], 0);
    tick();
    chk("basic_pulse", a_v[0], 0);

    // backpressure
    do_clr();
    ready = 0; en = 1; tick();
    for (int i = 0; i < 40; i++) begin
      in1 = 1'($urandom); in2 = 1'($urandom);
      in3 = 1'($urandom); tick();
    end
    chk("bp_drop", a_d[0], 1);
    chk("bp_hold", a_v[0], 1);
    ready = 1; tick();
    chk("bp_xfer", a_v[0], 0);
    repeat (5) tick();
    chk("bp_sticky", a_d[0], 1);

    // transfer and load on the same edge
    do_clr();
    ready = 0; en = 1; zero_in(); tick();
    for (int i = 0; i < 32; i++) begin
      in1 = (i < 16) ? 1'b1 : (i % 2 == 0);
      if (i == 31) ready = 1;
      tick();
    end
    chk("sim_valid", a_v[0], 1);
    chk("sim_cnt1", a_c1[0], 8);
    chk("sim_drop", a_d[0], 0);
    ready = 0; tick();

    // saturation in the narrow instance
    do_clr();
    ready = 1; en = 1; zero_in(); tick();
    for (int i = 0; i < 10; i++) begin
      in1 = 1; in2 = (i < 5); in3 = 0;
      tick();
    end
    chk("sat_valid", a_v[1], 1);
    chk("sat_cnt1", a_c1[1], 7);
    chk("sat_cnt2", a_c2[1], 5);
    chk("sat_flag", a_s[1], 1);

    // abort and restart
    do_clr();
    en = 1; zero_in(); tick();
    for (int i = 0; i < 5; i++) begin
      in1 = 1; tick();
    end
    en = 0; tick();
    chk("abort_busy", a_b[0], 0);
    en = 1; tick();
    chk("restart_busy", a_b[0], 1);
    for (int i = 0; i < 16; i++) begin
      in1 = (i % 2 == 1); tick();
      if (i == 14) chk("restart_early", a_v[0], 0);
    end
    chk("restart_valid", a_v[0], 1);
    chk("restart_cnt1", a_c1[0], 8);

    // reset pulse mid-window
    repeat (5) begin in1 = 1; tick(); end
    rstn = 0; tick();
    chk("rst2_valid", a_v[0], 0);
    chk("rst2_busy", a_b[0], 0);
    chk("rst2_cnt1", a_c1[0], 0);
    rstn = 1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rstn = ($urandom_range(0, 599) != 0);
      clr  = ($urandom_range(0, 399) == 0);
      en   = ($urandom_range(0, 59) != 0);
      in1  = 1'($urandom);
      in2  = ($urandom_range(0, 3) != 0);
      in3  = 1'($urandom);
      ready = (i % 1000 < 500) ? 1'($urandom)
            : ($urandom_range(0, 7) == 0);
      tick();
    end

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
